// File: rtl/logic_reduce_pipe.sv
// logic_reduce_pipe
//   Two-stage pipelined bitwise reducer. LANES operands of WIDTH bits are
//   combined with a selectable gate function (AND/NAND/OR/NOR/XOR/XNOR/PASS).
//   Both sides use valid/ready handshakes, and throughput is one transaction
//   per cycle.
//
//   Stage 1 registers A, LANE_MASK and OP.
//   Stage 2 computes the reduction and registers Y, ALL_ONE and ALL_ZERO.
//
// Ports
//   CLK        clock; all state changes on the rising edge
//   RST        synchronous active-high reset
//   A          operand bus; lane i is A[i*WIDTH +: WIDTH]
//   LANE_MASK  1 = lane takes part; 0 = lane is replaced by the op's identity
//   OP         000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR,
//              110 PASS, 111 reserved (gives Y = 0)
//   IN_VALID   A/LANE_MASK/OP valid
//   IN_READY   an input can be accepted this cycle (combinational from OUT_READY)
//   Y          result
//   ALL_ONE    Y is all ones
//   ALL_ZERO   Y is zero
//   OUT_VALID  Y and the flags are valid
//   OUT_READY  downstream accepts Y
//
// Optional feature (macro LOGIC_REDUCE_PIPE_ACC_EN)
//   ACC_CLR    input; clears the accumulator
//   ACC        output; fold of the delivered results by each transaction's OP family
//   ACC_EMPTY  output; no result has been folded since reset or the last clear
module logic_reduce_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [LANES*WIDTH-1:0] A,
  input  logic [LANES-1:0]       LANE_MASK,
  input  logic [2:0]             OP,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [WIDTH-1:0]       Y,
  output logic                   ALL_ONE,
  output logic                   ALL_ZERO,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY
`ifdef LOGIC_REDUCE_PIPE_ACC_EN
  ,
  input  logic                   ACC_CLR,
  output logic [WIDTH-1:0]       ACC,
  output logic                   ACC_EMPTY
`endif
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;

  // Stage 1 registers
  logic                   s1_valid_reg;
  logic [LANES*WIDTH-1:0] s1_a_reg;
  logic [LANES-1:0]       s1_mask_reg;
  logic [2:0]             s1_op_reg;

  // Stage 2 registers
  logic                   out_valid_reg;
  logic [WIDTH-1:0]       y_reg;
  logic                   all_one_reg;
  logic                   all_zero_reg;

  logic                   adv1;
  logic                   adv2;
  logic [WIDTH-1:0]       y_next;

  // A stage advances when it is empty or the stage after it is draining.
  assign adv2     = ~out_valid_reg | OUT_READY;
  assign adv1     = ~s1_valid_reg | adv2;
  assign IN_READY = adv1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_mask_reg  <= '0;
      s1_op_reg    <= '0;
    end else if (adv1) begin
      s1_valid_reg <= IN_VALID;
      if (IN_VALID) begin
        s1_a_reg    <= A;
        s1_mask_reg <= LANE_MASK;
        s1_op_reg   <= OP;
      end
    end
  end

  // Per-lane operands with the identity value substituted for masked lanes:
  // all ones for the AND family, zero for the OR/XOR families and PASS.
  logic [WIDTH-1:0] lane_ones[LANES];
  logic [WIDTH-1:0] lane_zero[LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_ones[gi] = s1_mask_reg[gi] ? s1_a_reg[gi*WIDTH +: WIDTH] : {WIDTH{1'b1}};
    assign lane_zero[gi] = s1_mask_reg[gi] ? s1_a_reg[gi*WIDTH +: WIDTH] : {WIDTH{1'b0}};
  end

  logic [WIDTH-1:0] and_red;
  logic [WIDTH-1:0] or_red;
  logic [WIDTH-1:0] xor_red;
  logic [WIDTH-1:0] pass_val;

  always_comb begin
    and_red  = {WIDTH{1'b1}};
    or_red   = {WIDTH{1'b0}};
    xor_red  = {WIDTH{1'b0}};
    pass_val = {WIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      and_red = and_red & lane_ones[i];
      or_red  = or_red  | lane_zero[i];
      xor_red = xor_red ^ lane_zero[i];
    end
    // Walk from the top so the lowest-index unmasked lane wins.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (s1_mask_reg[i]) begin
        pass_val = lane_zero[i];
      end
    end
  end

  always_comb begin
    y_next = {WIDTH{1'b0}};
    case (s1_op_reg)
      OP_AND:  y_next = and_red;
      OP_NAND: y_next = ~and_red;
      OP_OR:   y_next = or_red;
      OP_NOR:  y_next = ~or_red;
      OP_XOR:  y_next = xor_red;
      OP_XNOR: y_next = ~xor_red;
      OP_PASS: y_next = pass_val;
      default: y_next = {WIDTH{1'b0}};
    endcase
  end

  // The flags are registered from the same value as Y, so they always match it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_reg <= 1'b0;
      y_reg         <= '0;
      all_one_reg   <= 1'b0;
      all_zero_reg  <= 1'b1;
    end else if (adv2) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        y_reg        <= y_next;
        all_one_reg  <= &y_next;
        all_zero_reg <= ~|y_next;
      end
    end
  end

  assign Y         = y_reg;
  assign ALL_ONE   = all_one_reg;
  assign ALL_ZERO  = all_zero_reg;
  assign OUT_VALID = out_valid_reg;

`ifdef LOGIC_REDUCE_PIPE_ACC_EN
  // The accumulator folds by the OP of the transaction being delivered, so
  // stage 2 keeps that OP alongside Y.
  logic [2:0]       s2_op_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             acc_empty_reg;
  logic [WIDTH-1:0] acc_fold;
  logic             out_fire;

  assign out_fire = out_valid_reg & OUT_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_op_reg <= '0;
    end else if (adv2 && s1_valid_reg) begin
      s2_op_reg <= s1_op_reg;
    end
  end

  always_comb begin
    acc_fold = y_reg;
    case (s2_op_reg)
      OP_AND, OP_NAND: acc_fold = acc_reg & y_reg;
      OP_OR,  OP_NOR:  acc_fold = acc_reg | y_reg;
      OP_XOR, OP_XNOR: acc_fold = acc_reg ^ y_reg;
      default:         acc_fold = y_reg;
    endcase
  end

  // A clear in the same cycle as a delivery restarts the fold from that result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_reg       <= '0;
      acc_empty_reg <= 1'b1;
    end else if (out_fire) begin
      acc_reg       <= (ACC_CLR || acc_empty_reg) ? y_reg : acc_fold;
      acc_empty_reg <= 1'b0;
    end else if (ACC_CLR) begin
      acc_reg       <= '0;
      acc_empty_reg <= 1'b1;
    end
  end

  assign ACC       = acc_reg;
  assign ACC_EMPTY = acc_empty_reg;
`endif

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Directed bench for logic_reduce_pipe (WIDTH=8, LANES=4). Expected results
// are queued when an input handshake happens and compared when the matching
// output handshake happens.
module tb_logic_reduce_pipe;
  localparam int W = 8;
  localparam int L = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [L*W-1:0] A;
  logic [L-1:0]   LANE_MASK;
  logic [2:0]     OP;
  logic           IN_VALID;
  logic           IN_READY;
  logic [W-1:0]   Y;
  logic           ALL_ONE;
  logic           ALL_ZERO;
  logic           OUT_VALID;
  logic           OUT_READY;
`ifdef LOGIC_REDUCE_PIPE_ACC_EN
  logic           ACC_CLR;
  logic [W-1:0]   ACC;
  logic           ACC_EMPTY;
`endif

  always #5 CLK = ~CLK;

  logic_reduce_pipe #(.WIDTH(W), .LANES(L)) dut (
    .CLK(CLK), .RST(RST), .A(A), .LANE_MASK(LANE_MASK), .OP(OP),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Y(Y), .ALL_ONE(ALL_ONE),
    .ALL_ZERO(ALL_ZERO), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef LOGIC_REDUCE_PIPE_ACC_EN
    , .ACC_CLR(ACC_CLR), .ACC(ACC), .ACC_EMPTY(ACC_EMPTY)
`endif
  );

  logic [W+1:0] q[$];
  logic [W+1:0] cur_exp;
  logic [W+1:0] hold_val;
  logic         hold_pending = 1'b0;
  logic         in_fired;
  logic         toggle_en = 1'b0;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] pack(input logic [W-1:0] y);
    return {y, (y == {W{1'b1}}), (y == {W{1'b0}})};
  endfunction

  // Reference reduction: combine only the participating lanes.
  function automatic logic [W-1:0] model(input logic [L*W-1:0] a, input logic [L-1:0] m,
                                         input logic [2:0] op);
    logic [W-1:0] r;
    logic [W-1:0] v;
    bit found;
    r = '0;
    found = 0;
    case (op)
      3'd0, 3'd1: begin
        r = '1;
        for (int i = 0; i < L; i++) begin
          v = a[i*W +: W];
          if (m[i]) r = r & v;
        end
      end
      3'd2, 3'd3: for (int i = 0; i < L; i++) begin
        v = a[i*W +: W];
        if (m[i]) r = r | v;
      end
      3'd4, 3'd5: for (int i = 0; i < L; i++) begin
        v = a[i*W +: W];
        if (m[i]) r = r ^ v;
      end
      3'd6: for (int i = 0; i < L; i++) begin
        if (m[i] && !found) begin
          r = a[i*W +: W];
          found = 1;
        end
      end
      default: r = '0;
    endcase
    if (op == 3'd1 || op == 3'd3 || op == 3'd5) r = ~r;
    return r;
  endfunction

  // One clock: inputs are already driven; evaluate handshakes, then advance.
  task automatic tick();
    if (toggle_en) OUT_READY = (cyc % 3 == 0);
    cyc++;
    #1;
    in_fired = 1'b0;
    if (hold_pending && !RST) begin
      chk("stall_hold", {22'b0, OUT_VALID, Y, ALL_ONE, ALL_ZERO}, {22'b0, 1'b1, hold_val});
    end
    hold_pending = 1'b0;
    if (!RST) begin
      chk("in_ready", {31'b0, IN_READY}, {31'b0, !(q.size() >= 2 && !OUT_READY)});
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          chk("spurious_out", {31'b0, OUT_VALID}, 32'd0);
        end else begin
          logic [W+1:0] e;
          e = q.pop_front();
          chk("result", {22'b0, Y, ALL_ONE, ALL_ZERO}, {22'b0, e});
          $display("out: Y=%h one=%b zero=%b", Y, ALL_ONE, ALL_ZERO);
        end
      end
      if (OUT_VALID && !OUT_READY) begin
        hold_pending = 1'b1;
        hold_val = {Y, ALL_ONE, ALL_ZERO};
      end
      if (IN_VALID && IN_READY) begin
        q.push_back(cur_exp);
        in_fired = 1'b1;
        $display("in : A=%h mask=%b op=%0d", A, LANE_MASK, OP);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic send(input logic [L*W-1:0] a, input logic [L-1:0] m, input logic [2:0] op,
                      input logic [W-1:0] exp_y);
    int n;
    A = a; LANE_MASK = m; OP = op; IN_VALID = 1'b1;
    cur_exp = pack(exp_y);
    n = 0;
    do begin
      tick();
      n++;
    end while (!in_fired && n < 50);
    if (!in_fired) chk("send_timeout", {31'b0, IN_READY}, 32'd1);
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    if (!toggle_en) OUT_READY = 1'b1;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  localparam logic [L*W-1:0] TV = {8'hF0, 8'hFF, 8'hF3, 8'hF5};

  initial begin
    RST = 1'b1; A = '0; LANE_MASK = '0; OP = '0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    cur_exp = '0;
`ifdef LOGIC_REDUCE_PIPE_ACC_EN
    ACC_CLR = 1'b0;
`endif
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_y_flags", {22'b0, Y, ALL_ONE, ALL_ZERO}, {22'b0, 8'h00, 1'b0, 1'b1});
    chk("rst_in_ready", {31'b0, IN_READY}, 32'd1);
    @(negedge CLK);

    // AND over all lanes, with an exact latency check
    send(TV, 4'hF, 3'd0, 8'hF0);
    chk("lat_cycle1", {31'b0, OUT_VALID}, 32'd0);
    tick();
    chk("lat_cycle2", {31'b0, OUT_VALID}, 32'd1);
    drain();

    send(TV, 4'b0011, 3'd4, 8'h06);
    send(TV, 4'h0,    3'd3, 8'hFF);
    send(TV, 4'b0100, 3'd6, 8'hFF);
    send(TV, 4'h0,    3'd6, 8'h00);
    send(TV, 4'hF,    3'd7, 8'h00);
    send(TV, 4'h0,    3'd0, 8'hFF);
    send(TV, 4'h0,    3'd1, 8'h00);
    send(TV, 4'h0,    3'd5, 8'hFF);
    drain();

    // Back-to-back stream under a 1,0,0 OUT_READY pattern
    toggle_en = 1'b1;
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      logic [L*W-1:0] a;
      logic [L-1:0]   m;
      logic [2:0]     op;
      a  = $urandom;
      m  = L'($urandom_range(0, 15));
      op = 3'($urandom_range(0, 7));
      send(a, m, op, model(a, m, op));
    end
    drain();
    toggle_en = 1'b0;
    OUT_READY = 1'b1;

    // Reset with two transactions in flight
    OUT_READY = 1'b0;
    send(TV, 4'hF, 3'd2, 8'hFF);
    send(TV, 4'hF, 3'd0, 8'hF0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    q.delete();
    #1;
    chk("rst2_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst2_y_flags", {22'b0, Y, ALL_ONE, ALL_ZERO}, {22'b0, 8'h00, 1'b0, 1'b1});
    @(negedge CLK);
    OUT_READY = 1'b1;
    send(TV, 4'b0011, 3'd4, 8'h06);
    chk("rst2_lat1", {31'b0, OUT_VALID}, 32'd0);
    tick();
    chk("rst2_lat2", {31'b0, OUT_VALID}, 32'd1);
    drain();

`ifdef LOGIC_REDUCE_PIPE_ACC_EN
    ACC_CLR = 1'b1;
    tick();
    ACC_CLR = 1'b0;
    chk("acc_clr", {23'b0, ACC, ACC_EMPTY}, {23'b0, 8'h00, 1'b1});
    send(TV, 4'hF, 3'd0, 8'hF0);
    send({8'h3C, 8'hFF, 8'hFF, 8'hFF}, 4'hF, 3'd0, 8'h3C);
    drain();
    chk("acc_and", {23'b0, ACC, ACC_EMPTY}, {23'b0, 8'h30, 1'b0});
    OUT_READY = 1'b0;
    send({24'h0, 8'hAA}, 4'b0001, 3'd6, 8'hAA);
    for (int n = 0; n < 10 && !OUT_VALID; n++) tick();
    chk("acc_wait_out", {31'b0, OUT_VALID}, 32'd1);
    ACC_CLR = 1'b1;
    OUT_READY = 1'b1;
    tick();
    ACC_CLR = 1'b0;
    chk("acc_clr_fire", {23'b0, ACC, ACC_EMPTY}, {23'b0, 8'hAA, 1'b0});
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
